serial_word_framer: RTL and testbench
=====================================

Name: serial_word_framer

Overview:
Upstream front-end for the 6-bit parallel capture register stage. It receives an asynchronous serial line and frames it into 6-bit words: start bit, 6 data bits LSB-first, stop bit. It presents each completed word on a parallel bus with a one-cycle valid strobe and a frame-error flag. The bit period is programmable from the pins.

Parameters:
DATA_W, 6, data bits per frame; must be ≤6 so the word fits io_out[5:0]; unused upper bits read 0
DIV_W, 4, width of the bit-period select field io_in[7:4]

Ports:
io_in[0]  input  1  clock; all flops rising-edge
io_in[1]  input  1  rst_n; asynchronous assert, active-low, synchronous release at top level
io_in[2]  input  1  rx; serial line, idle-high
io_in[3]  input  1  en; 1 = receiver armed, 0 = abort/idle
io_in[7:4]  input  4  div; bit period P = div+1 clocks (1..16)
io_out[5:0]  output  6  word; last good received word
io_out[6]  output  1  valid; one-cycle pulse on each good frame
io_out[7]  output  1  err; frame error flag

Behaviour:
- Reset (rst_n=0, async): word=0, valid=0, err=0, FSM=IDLE, both rx synchroniser flops=1, counters=0.
- rx passes a 2-flop synchroniser (rxs). All decisions use rxs. An edge on io_in[2] is visible 2 clocks later.
- States: IDLE, START, DATA, STOP, BRK.
- IDLE: if en=1 and rxs=0, latch P=div+1 into an internal register, load cnt=(P-1)>>1, bit index=0, go to START. div changes mid-frame are ignored.
- START: cnt decrements each clock. At cnt=0, sample rxs:
  - 0: load cnt=P-1, go to DATA.
  - 1: false start; go to IDLE, no flags change.
- DATA: at cnt=0, shift rxs into shift register LSB-first, bit index++, reload cnt=P-1. After bit DATA_W-1, go to STOP.
- STOP: at cnt=0, sample rxs:
  - 1: word←shift register, valid=1 for exactly one clock, err=0, go to IDLE.
  - 0: err=1, word unchanged, no valid, go to BRK.
- BRK: stay while rxs=0; go to IDLE when rxs=1. This stops a held-low line from re-triggering.
- err is sticky until the next good frame or reset.
- en=0 in any state: next clock go to IDLE, partial frame discarded, word/err held, valid=0.
- P=1: cnt loads 0 everywhere, so one sample per clock. Legal.
- Latency: valid rises at the clock after the stop-bit sample point. Stop-bit sample is ≈2 + (P-1)>>1 + (DATA_W+1)·P clocks after the start edge on io_in[2].
- valid is never asserted in two consecutive cycles. The minimum gap between valid pulses is one full frame.

Optional Feature:
PARITY_EN
- Defined: an even-parity bit is received after the last data bit, in a PARITY state between DATA and STOP with the same cnt timing.
- Parity mismatch: err=1, no valid, word unchanged. The stop bit is still checked, and BRK rules apply if it is low.
- Undefined: no PARITY state; frame is start + DATA_W + stop exactly as above.

Test Plan:
- Reset: rst_n=0 mid-DATA with rx toggling → io_out=0x00 immediately (asynchronous); after release FSM=IDLE and the next frame is received correctly.
- Good frame: div=3 (P=4), en=1, send 0x2D (start, bits 1,0,1,1,0,1, stop) → io_out[5:0]=0x2D, io_out[6] high exactly 1 clock, io_out[7]=0.
- Glitch: div=7 (P=8), rx low for 1 clock then high → no valid, word unchanged, FSM back in IDLE; a following frame 0x15 is received correctly.
- Framing error: div=3, send 0x3F with stop bit=0, then hold rx low 40 clocks → err=1, word keeps previous value, no valid, no restart. Raise rx, send 0x0A → word=0x0A, valid pulse, err=0.
- Abort: div=0 (P=1), drop en after the 3rd data bit, then re-raise en and send 0x21 → partial frame ignored, then word=0x21 with one valid pulse.
- PARITY_EN build, div=3: send 0x07 with parity 1 → valid, word=0x07. Send 0x07 with parity 0 → err=1, no valid, word stays 0x07.

Source files
------------

// File: rtl/serial_word_framer.sv
// ---------------------------------------------------------------------------
// serial_word_framer
//
// Purpose:
//   Receives an asynchronous, idle-high serial line and frames it into
//   DATA_W-bit words: one start bit (0), DATA_W data bits LSB-first, and one
//   stop bit (1). Each good word is presented on io_out[5:0] with a one-clock
//   valid strobe. A frame error sets a sticky err flag. The bit period is
//   P = div+1 clocks and is taken from the pins at each start bit.
//
// Optional feature (macro PARITY_EN):
//   When defined, an even-parity bit follows the last data bit. A parity
//   mismatch raises err and suppresses valid. The stop bit is still checked.
//
// Ports:
//   io_in[0]      clock, all flops rising-edge
//   io_in[1]      rst_n, asynchronous active-low reset
//   io_in[2]      rx, serial line (idle high)
//   io_in[3]      en, 1 = receiver armed, 0 = abort to idle
//   io_in[7:4]    div, bit period select, P = div+1 clocks
//   io_out[5:0]   last good received word (unused upper bits read 0)
//   io_out[6]     valid, one-clock strobe per good frame
//   io_out[7]     err, sticky frame-error flag
//   o_dbg_state   current FSM state, for observation only
//
// Handshake: valid is a push-only strobe with no ready. The consumer must
//   capture io_out[5:0] in the cycle valid is high. The word then stays
//   stable until the next good frame.
// ---------------------------------------------------------------------------
module serial_word_framer #(
  parameter int DATA_W = 6,
  parameter int DIV_W  = 4
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out,
  output logic [2:0] o_dbg_state
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
  localparam logic [2:0] S_BRK    = 3'd4;
  localparam logic [2:0] S_PARITY = 3'd5;

  logic             w_clk;
  logic             w_rst_n;
  logic             w_rx;
  logic             w_en;
  logic [DIV_W-1:0] w_div;
  logic             w_rxs;
  logic [5:0]       w_word_ext;

  logic [2:0]        r_state;
  logic              r_rx_meta;
  logic              r_rx_sync;
  logic [DIV_W-1:0]  r_per_m1;   // latched P-1 for the frame in flight
  logic [DIV_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_word;
  logic              r_valid;
  logic              r_err;
`ifdef PARITY_EN
  logic              r_par;      // running XOR of data bits
  logic              r_par_bad;  // parity mismatch seen in this frame
`endif

  assign w_clk   = io_in[0];
  assign w_rst_n = io_in[1];
  assign w_rx    = io_in[2];
  assign w_en    = io_in[3];
  assign w_div   = io_in[4 +: DIV_W];
  assign w_rxs   = r_rx_sync;

  always_comb begin
    w_word_ext = '0;
    w_word_ext[DATA_W-1:0] = r_word;
  end

  assign io_out      = {r_err, r_valid, w_word_ext};
  assign o_dbg_state = r_state;

  // Two-flop synchroniser, reset to the idle (high) line level.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= w_rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state   <= S_IDLE;
      r_per_m1  <= '0;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_word    <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
`ifdef PARITY_EN
      r_par     <= 1'b0;
      r_par_bad <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      if (!w_en) begin
        // Abort: drop any partial frame and keep word/err as they are.
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (!w_rxs) begin
              r_per_m1  <= w_div;
              r_idx     <= '0;
`ifdef PARITY_EN
              r_par     <= 1'b0;
              r_par_bad <= 1'b0;
`endif
              // With a one-clock bit period the detecting sample is already
              // the only start-bit sample. A START pass would land on data
              // bit 0, so go straight to DATA.
              if (w_div == '0) begin
                r_cnt   <= '0;
                r_state <= S_DATA;
              end else begin
                r_cnt   <= w_div >> 1;
                r_state <= S_START;
              end
            end
          end

          S_START: begin
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - DIV_W'(1);
            end else if (!w_rxs) begin
              r_cnt   <= r_per_m1;
              r_state <= S_DATA;
            end else begin
              r_state <= S_IDLE;  // false start, flags untouched
            end
          end

          S_DATA: begin
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - DIV_W'(1);
            end else begin
              r_shift <= {w_rxs, r_shift[DATA_W-1:1]};
`ifdef PARITY_EN
              r_par   <= r_par ^ w_rxs;
`endif
              r_cnt   <= r_per_m1;
              r_idx   <= r_idx + IDX_W'(1);
              if (r_idx == IDX_W'(DATA_W - 1)) begin
`ifdef PARITY_EN
                r_state <= S_PARITY;
`else
                r_state <= S_STOP;
`endif
              end
            end
          end

`ifdef PARITY_EN
          S_PARITY: begin
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - DIV_W'(1);
            end else begin
              // Even parity: data bits plus parity bit must XOR to 0.
              r_par_bad <= r_par ^ w_rxs;
              r_cnt     <= r_per_m1;
              r_state   <= S_STOP;
            end
          end
`endif

          S_STOP: begin
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - DIV_W'(1);
            end else if (w_rxs) begin
`ifdef PARITY_EN
              if (r_par_bad) begin
                r_err <= 1'b1;
              end else begin
                r_word  <= r_shift;
                r_valid <= 1'b1;
                r_err   <= 1'b0;
              end
`else
              r_word  <= r_shift;
              r_valid <= 1'b1;
              r_err   <= 1'b0;
`endif
              r_state <= S_IDLE;
            end else begin
              r_err   <= 1'b1;
              r_state <= S_BRK;
            end
          end

          // A line held low after a bad stop bit must not look like a
          // fresh start bit. Wait for it to return high first.
          S_BRK: begin
            if (w_rxs) r_state <= S_IDLE;
          end

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_word_framer.sv
// ---------------------------------------------------------------------------
// tb_serial_word_framer
//
// Directed bench for serial_word_framer. Frames are driven bit by bit on
// rx, on falling clock edges. Outputs are checked on falling edges against
// hand-computed values. A monitor counts clocks with valid high and checks
// that valid is never high in two consecutive cycles.
// ---------------------------------------------------------------------------
module tb_serial_word_framer;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_BRK  = 3'd4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic       en    = 1'b0;
  logic [3:0] div   = 4'd0;
  logic [7:0] io_in;
  logic [7:0] io_out;
  logic [2:0] dbg_state;

  int   n_vec        = 0;
  int   n_err        = 0;
  int   valid_cycles = 0;
  int   v0           = 0;
  logic prev_valid   = 1'b0;

  assign io_in = {div, en, rx, rst_n, clk};

  always #5 clk = ~clk;

  serial_word_framer dut (
    .io_in       (io_in),
    .io_out      (io_out),
    .o_dbg_state (dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Counts strobe cycles. Valid must never be high two cycles running.
  always @(negedge clk) begin
    if (io_out[6] === 1'b1) begin
      valid_cycles++;
      chk("valid_not_back_to_back", 32'(prev_valid), 32'd0);
    end
    prev_valid = io_out[6];
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives a whole frame at the current div, leaving rx at the stop level.
  task automatic send_frame(input logic [5:0] data, input logic stop_bit,
                            input logic par_flip);
    int per;
    per = int'(div) + 1;
    rx = 1'b0;
    hold(per);
    for (int i = 0; i < 6; i++) begin
      rx = data[i];
      hold(per);
    end
`ifdef PARITY_EN
    rx = (^data) ^ par_flip;
    hold(per);
`else
    if (par_flip) $display("note: parity flip has no effect in this build");
`endif
    rx = stop_bit;
    hold(per);
  endtask

  initial begin
    // ---------------- reset ----------------
    hold(2);
    chk("reset_io_out", 32'(io_out), 32'h00);
    chk("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    hold(2);
    en  = 1'b1;
    div = 4'd3;
    hold(2);

    // ---------------- good frame, P=4 ----------------
    v0 = valid_cycles;
    send_frame(6'h2D, 1'b1, 1'b0);
    rx = 1'b1;
    hold(14);
    chk("good_word", 32'(io_out[5:0]), 32'h2D);
    chk("good_valid_count", 32'(valid_cycles - v0), 32'd1);
    chk("good_err", 32'(io_out[7]), 32'd0);
    chk("good_state", 32'(dbg_state), 32'(ST_IDLE));

    // ---------------- glitch, P=8 ----------------
    div = 4'd7;
    hold(2);
    v0 = valid_cycles;
    rx = 1'b0;
    hold(1);
    rx = 1'b1;
    hold(20);
    chk("glitch_valid_count", 32'(valid_cycles - v0), 32'd0);
    chk("glitch_word", 32'(io_out[5:0]), 32'h2D);
    chk("glitch_err", 32'(io_out[7]), 32'd0);
    chk("glitch_state", 32'(dbg_state), 32'(ST_IDLE));
    v0 = valid_cycles;
    send_frame(6'h15, 1'b1, 1'b0);
    rx = 1'b1;
    hold(22);
    chk("after_glitch_word", 32'(io_out[5:0]), 32'h15);
    chk("after_glitch_valid_count", 32'(valid_cycles - v0), 32'd1);

    // ---------------- framing error + held-low line ----------------
    div = 4'd3;
    hold(2);
    v0 = valid_cycles;
    send_frame(6'h3F, 1'b0, 1'b0);
    rx = 1'b0;
    hold(40);
    chk("ferr_err", 32'(io_out[7]), 32'd1);
    chk("ferr_word", 32'(io_out[5:0]), 32'h15);
    chk("ferr_valid_count", 32'(valid_cycles - v0), 32'd0);
    chk("ferr_state_brk", 32'(dbg_state), 32'(ST_BRK));
    rx = 1'b1;
    hold(4);
    chk("brk_release_state", 32'(dbg_state), 32'(ST_IDLE));
    v0 = valid_cycles;
    send_frame(6'h0A, 1'b1, 1'b0);
    rx = 1'b1;
    hold(14);
    chk("recover_word", 32'(io_out[5:0]), 32'h0A);
    chk("recover_valid_count", 32'(valid_cycles - v0), 32'd1);
    chk("recover_err_cleared", 32'(io_out[7]), 32'd0);

    // ---------------- abort, P=1 ----------------
    div = 4'd0;
    hold(2);
    v0 = valid_cycles;
    rx = 1'b0;       // start
    hold(1);
    rx = 1'b1;       // bit0
    hold(1);
    rx = 1'b0;       // bit1
    hold(1);
    rx = 1'b1;       // bit2
    hold(1);
    en = 1'b0;
    rx = 1'b1;
    hold(1);
    chk("abort_state", 32'(dbg_state), 32'(ST_IDLE));
    hold(5);
    chk("abort_valid_count", 32'(valid_cycles - v0), 32'd0);
    chk("abort_word_held", 32'(io_out[5:0]), 32'h0A);
    en = 1'b1;
    hold(3);
    v0 = valid_cycles;
    send_frame(6'h21, 1'b1, 1'b0);
    rx = 1'b1;
    hold(8);
    chk("p1_word", 32'(io_out[5:0]), 32'h21);
    chk("p1_valid_count", 32'(valid_cycles - v0), 32'd1);
    chk("p1_err", 32'(io_out[7]), 32'd0);

    // ---------------- async reset mid-DATA ----------------
    div = 4'd3;
    hold(2);
    rx = 1'b0;       // start
    hold(4);
    rx = 1'b1;       // bit0
    hold(4);
    rx = 1'b0;       // bit1, part way
    hold(2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_io_out", 32'(io_out), 32'h00);
    chk("async_reset_state", 32'(dbg_state), 32'(ST_IDLE));
    hold(1);
    rx = 1'b1;
    hold(1);
    rx = 1'b0;
    hold(1);
    rx = 1'b1;
    hold(1);
    chk("in_reset_io_out", 32'(io_out), 32'h00);
    rst_n = 1'b1;
    hold(1);
    chk("post_reset_state", 32'(dbg_state), 32'(ST_IDLE));
    hold(2);
    v0 = valid_cycles;
    send_frame(6'h33, 1'b1, 1'b0);
    rx = 1'b1;
    hold(14);
    chk("post_reset_word", 32'(io_out[5:0]), 32'h33);
    chk("post_reset_valid_count", 32'(valid_cycles - v0), 32'd1);

`ifdef PARITY_EN
    // ---------------- parity, P=4 ----------------
    v0 = valid_cycles;
    send_frame(6'h07, 1'b1, 1'b0);
    rx = 1'b1;
    hold(14);
    chk("par_ok_word", 32'(io_out[5:0]), 32'h07);
    chk("par_ok_valid_count", 32'(valid_cycles - v0), 32'd1);
    chk("par_ok_err", 32'(io_out[7]), 32'd0);
    v0 = valid_cycles;
    send_frame(6'h07, 1'b1, 1'b1);
    rx = 1'b1;
    hold(14);
    chk("par_bad_err", 32'(io_out[7]), 32'd1);
    chk("par_bad_word", 32'(io_out[5:0]), 32'h07);
    chk("par_bad_valid_count", 32'(valid_cycles - v0), 32'd0);
    chk("par_bad_state", 32'(dbg_state), 32'(ST_IDLE));
`endif

    hold(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
